// File: rtl/llc_mshr_pkg.sv
// Shared types and sizing for the LLC miss-status holding register table.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package llc_mshr_pkg;

    localparam int LLC_N_MSHR     = 16;
    localparam int LLC_SET_BITS   = 9;
    localparam int LLC_TAG_BITS   = 18;
    localparam int LLC_WAY_BITS   = 4;
    localparam int LLC_STATE_BITS = 4;
    localparam int MSHR_BITS      = $clog2(LLC_N_MSHR);

    // One outstanding-line record. Field widths are fixed here, so any
    // width change must be made in this package, not via module parameters.
    typedef struct packed {
        logic                      valid;
        logic [LLC_SET_BITS-1:0]   set;
        logic [LLC_TAG_BITS-1:0]   tag;
        logic [LLC_WAY_BITS-1:0]   way;
        logic [LLC_STATE_BITS-1:0] state;
    } llc_mshr_entry_t;

endpackage

// File: rtl/llc_mshr_prio_enc.sv
// Lowest-set-bit priority encoder.
// Latency: combinational.
// Backpressure: none; found=0 and idx=0 when no request bit is set.
// Ports: req_vec (N request bits), found (any bit set), idx (lowest set bit).
module llc_mshr_prio_enc #(
    parameter  int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req_vec,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from the top down so the last (lowest) hit wins.
    always_comb begin
        found = |req_vec;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/llc_mshr_table.sv
// LLC MSHR table: tracks outstanding lines, allocates lowest free entry, searches by set/tag.
// Latency: alloc/update/free take effect next edge; lookup results 1 cycle after lookup_en.
// Backpressure: alloc_ready=0 when all entries are valid; free in the same cycle is not bypassed.
// Ports: alloc_* allocate, upd_* rewrite state, free_* release, lookup_* search (registered),
//        add_mshr_entry / incr_mshr_cnt net-occupancy pulses, occupancy = count of valid entries.
module llc_mshr_table
    import llc_mshr_pkg::*;
#(
    parameter  int N_MSHR     = LLC_N_MSHR,
    parameter  int SET_BITS   = LLC_SET_BITS,
    parameter  int TAG_BITS   = LLC_TAG_BITS,
    parameter  int WAY_BITS   = LLC_WAY_BITS,
    parameter  int STATE_BITS = LLC_STATE_BITS,
    localparam int IDX_BITS   = $clog2(N_MSHR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [SET_BITS-1:0]   alloc_set,
    input  logic [TAG_BITS-1:0]   alloc_tag,
    input  logic [WAY_BITS-1:0]   alloc_way,
    input  logic [STATE_BITS-1:0] alloc_state,
    output logic [IDX_BITS-1:0]   alloc_idx,
    input  logic                  upd_en,
    input  logic [IDX_BITS-1:0]   upd_idx,
    input  logic [STATE_BITS-1:0] upd_state,
    input  logic                  free_en,
    input  logic [IDX_BITS-1:0]   free_idx,
    input  logic                  lookup_en,
    input  logic [SET_BITS-1:0]   lookup_set,
    input  logic [TAG_BITS-1:0]   lookup_tag,
    output logic                  lookup_done,
    output logic                  lookup_hit,
    output logic [IDX_BITS-1:0]   lookup_hit_idx,
    output logic [STATE_BITS-1:0] lookup_hit_state,
    output logic                  set_conflict_det,
    output logic                  add_mshr_entry,
    output logic                  incr_mshr_cnt,
    output logic [IDX_BITS:0]     occupancy
);

    llc_mshr_entry_t entries_q [N_MSHR];
    llc_mshr_entry_t entries_d [N_MSHR];

    logic [IDX_BITS:0]     occupancy_q, occupancy_d;
    logic                  lookup_done_q, lookup_done_d;
    logic                  lookup_hit_q, lookup_hit_d;
    logic [IDX_BITS-1:0]   lookup_hit_idx_q, lookup_hit_idx_d;
    logic [STATE_BITS-1:0] lookup_hit_state_q, lookup_hit_state_d;
    logic                  set_conflict_q, set_conflict_d;

    logic [N_MSHR-1:0]     free_vec;
    logic [N_MSHR-1:0]     match_vec;
    logic [N_MSHR-1:0]     conflict_vec;
    logic                  free_found;
    logic                  hit_found;
    logic [IDX_BITS-1:0]   hit_idx;
    logic                  alloc_acc;
    logic                  free_eff;
    logic                  upd_eff;

    always_comb begin
        for (int i = 0; i < N_MSHR; i++) begin
            free_vec[i]     = ~entries_q[i].valid;
            conflict_vec[i] = entries_q[i].valid && (entries_q[i].set == lookup_set);
            match_vec[i]    = conflict_vec[i] && (entries_q[i].tag == lookup_tag);
        end
    end

    llc_mshr_prio_enc #(.N(N_MSHR)) u_free_sel (
        .req_vec (free_vec),
        .found   (free_found),
        .idx     (alloc_idx)
    );

    llc_mshr_prio_enc #(.N(N_MSHR)) u_hit_sel (
        .req_vec (match_vec),
        .found   (hit_found),
        .idx     (hit_idx)
    );

    assign alloc_ready = free_found;
    assign alloc_acc   = alloc_valid & alloc_ready;
    assign free_eff    = free_en & entries_q[free_idx].valid;
    // A free to the same entry wins over an update.
    assign upd_eff     = upd_en & entries_q[upd_idx].valid & ~(free_eff & (free_idx == upd_idx));

    // Simultaneous alloc and free net to zero; the downstream counter
    // prioritises decrement, so raising both would lose a count.
    assign add_mshr_entry = alloc_acc & ~free_eff;
    assign incr_mshr_cnt  = free_eff & ~alloc_acc;

    always_comb begin
        for (int i = 0; i < N_MSHR; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (upd_eff) begin
            entries_d[upd_idx].state = upd_state;
        end
        if (free_eff) begin
            entries_d[free_idx].valid = 1'b0;
        end
        // The allocated entry is invalid, so it never collides with upd/free.
        if (alloc_acc) begin
            entries_d[alloc_idx] = '{valid: 1'b1, set: alloc_set, tag: alloc_tag,
                                     way: alloc_way, state: alloc_state};
        end
    end

    always_comb begin
        occupancy_d = occupancy_q;
        if (add_mshr_entry) begin
            occupancy_d = occupancy_q + 1'b1;
        end else if (incr_mshr_cnt) begin
            occupancy_d = occupancy_q - 1'b1;
        end
    end

    // Results hold between lookups; only lookup_done drops back to 0.
    always_comb begin
        lookup_done_d      = lookup_en;
        lookup_hit_d       = lookup_hit_q;
        lookup_hit_idx_d   = lookup_hit_idx_q;
        lookup_hit_state_d = lookup_hit_state_q;
        set_conflict_d     = set_conflict_q;
        if (lookup_en) begin
            lookup_hit_d       = hit_found;
            lookup_hit_idx_d   = hit_idx;
            lookup_hit_state_d = hit_found ? entries_q[hit_idx].state : '0;
            set_conflict_d     = |conflict_vec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_MSHR; i++) begin
                entries_q[i] <= '0;
            end
            occupancy_q        <= '0;
            lookup_done_q      <= 1'b0;
            lookup_hit_q       <= 1'b0;
            lookup_hit_idx_q   <= '0;
            lookup_hit_state_q <= '0;
            set_conflict_q     <= 1'b0;
        end else begin
            for (int i = 0; i < N_MSHR; i++) begin
                entries_q[i] <= entries_d[i];
            end
            occupancy_q        <= occupancy_d;
            lookup_done_q      <= lookup_done_d;
            lookup_hit_q       <= lookup_hit_d;
            lookup_hit_idx_q   <= lookup_hit_idx_d;
            lookup_hit_state_q <= lookup_hit_state_d;
            set_conflict_q     <= set_conflict_d;
        end
    end

    assign occupancy        = occupancy_q;
    assign lookup_done      = lookup_done_q;
    assign lookup_hit       = lookup_hit_q;
    assign lookup_hit_idx   = lookup_hit_idx_q;
    assign lookup_hit_state = lookup_hit_state_q;
    assign set_conflict_det = set_conflict_q;

endmodule
